// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module    : riscv_pkg
//  Purpose   : Shared types for the ID/EX stage: ALU operation encodings,
//              the EX control bundle and the operand-source select.
//  Revision  : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_SLT = 4'b1001
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic alu_src;
  } ex_ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // rs2 is a real operand unless the immediate replaces it; stores
  // always need rs2 as their write data.
  function automatic logic uses_rs2(input logic alu_src, input logic mem_write);
    return ~alu_src | mem_write;
  endfunction

endpackage
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
//  Module    : forward_unit
//  Purpose   : Finds which in-flight producer (if any) writes a given source
//              register. The "exmem" producer is the younger one and wins
//              when both match. x0 is never reported as produced.
//  Ports     : rs               in  source register index
//              exmem_reg_write  in  younger producer write enable
//              exmem_rd         in  younger producer destination
//              memwb_reg_write  in  older producer write enable
//              memwb_rd         in  older producer destination
//              sel              out FWD_EXMEM / FWD_MEMWB / FWD_RF
//  Revision  : 1.0 - initial release
// ============================================================================
module forward_unit
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  output fwd_sel_e              sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = exmem_reg_write & (exmem_rd != '0) & (exmem_rd == rs);
  assign w_memwb_hit = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == rs);

  always_comb begin
    sel = FWD_RF;
    if (w_exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module    : id_ex_stage
//  Purpose   : ID/EX pipeline register with operand forwarding and hazard
//              stall generation, feeding the ALU.
//  Config    : ID_EX_FWD_EN defined   -> EX/MEM and MEM/WB forwarding into
//                                        SrcA/SrcB/ex_store_data; only
//                                        load-use hazards stall.
//              ID_EX_FWD_EN undefined -> operands come straight from the
//                                        EX register; any RAW against EX or
//                                        EX/MEM stalls.
//  Ports     : clk, reset (sync, active-high)
//              id_*            decoded instruction from ID
//              flush           kill the instruction entering EX
//              exmem_*/memwb_* downstream writers (forwarding/hazards)
//              stall           hold PC and IF/ID (combinational)
//              SrcA/SrcB       ALU operands, Operation registered ALU op
//              ex_store_data   forwarded rs2 for stores
//              ex_*            registered EX fields
//  Revision  : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_mem_to_reg,
  input  logic                     id_branch,
  input  logic                     flush,
  input  logic                     exmem_reg_write,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic                     stall,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_mem_to_reg,
  output logic                     ex_branch
);

  // --------------------------------------------------------------------------
  // EX state
  // --------------------------------------------------------------------------
  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_pc;
  logic [DATA_WIDTH-1:0]    r_rs1_data;
  logic [DATA_WIDTH-1:0]    r_rs2_data;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic [REG_ADDR_W-1:0]    r_rs1;
  logic [REG_ADDR_W-1:0]    r_rs2;
  logic [REG_ADDR_W-1:0]    r_rd;
  logic [OPCODE_LENGTH-1:0] r_op;
  ex_ctrl_t                 r_ctrl;

  ex_ctrl_t                 w_id_ctrl;
  logic                     w_uses_rs2;
  logic                     w_hazard;
  logic [DATA_WIDTH-1:0]    w_fwd_a;
  logic [DATA_WIDTH-1:0]    w_fwd_b;
  fwd_sel_e                 w_sel_a;
  fwd_sel_e                 w_sel_b;

  // An invalid ID slot must not carry side effects into EX.
  always_comb begin
    w_id_ctrl = '0;
    if (id_valid) begin
      w_id_ctrl.reg_write  = id_reg_write;
      w_id_ctrl.mem_read   = id_mem_read;
      w_id_ctrl.mem_write  = id_mem_write;
      w_id_ctrl.mem_to_reg = id_mem_to_reg;
      w_id_ctrl.branch     = id_branch;
      w_id_ctrl.alu_src    = id_alu_src;
    end
  end

  assign w_uses_rs2 = uses_rs2(id_alu_src, id_mem_write);

`ifdef ID_EX_FWD_EN
  // --------------------------------------------------------------------------
  // Forwarding: operand selection for the instruction currently in EX.
  // --------------------------------------------------------------------------
  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs              (r_rs1),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (w_sel_a)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs              (r_rs2),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (w_sel_b)
  );

  always_comb begin
    w_fwd_a = r_rs1_data;
    case (w_sel_a)
      FWD_EXMEM: w_fwd_a = exmem_result;
      FWD_MEMWB: w_fwd_a = memwb_result;
      default:   w_fwd_a = r_rs1_data;
    endcase
  end

  always_comb begin
    w_fwd_b = r_rs2_data;
    case (w_sel_b)
      FWD_EXMEM: w_fwd_b = exmem_result;
      FWD_MEMWB: w_fwd_b = memwb_result;
      default:   w_fwd_b = r_rs2_data;
    endcase
  end

  // Only a load in EX cannot be forwarded in time: its data appears in MEM.
  assign w_hazard = id_valid & r_valid & r_ctrl.mem_read & (r_rd != '0) &
                    ((r_rd == id_rs1) | (w_uses_rs2 & (r_rd == id_rs2)));
`else
  // --------------------------------------------------------------------------
  // No forwarding: the ID sources are checked against the two producers that
  // have not yet written the register file (EX, then EX/MEM). The forward
  // unit's priority lookup doubles as a "is this register pending" test.
  // --------------------------------------------------------------------------
  logic w_ex_writes;
  logic w_unused_fwd_inputs;

  assign w_ex_writes = r_valid & r_ctrl.reg_write;

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_haz_a (
    .rs              (id_rs1),
    .exmem_reg_write (w_ex_writes),
    .exmem_rd        (r_rd),
    .memwb_reg_write (exmem_reg_write),
    .memwb_rd        (exmem_rd),
    .sel             (w_sel_a)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_haz_b (
    .rs              (id_rs2),
    .exmem_reg_write (w_ex_writes),
    .exmem_rd        (r_rd),
    .memwb_reg_write (exmem_reg_write),
    .memwb_rd        (exmem_rd),
    .sel             (w_sel_b)
  );

  assign w_fwd_a  = r_rs1_data;
  assign w_fwd_b  = r_rs2_data;
  assign w_hazard = id_valid &
                    ((w_sel_a != FWD_RF) | (w_uses_rs2 & (w_sel_b != FWD_RF)));

  // Forwarding-only inputs and EX source indices have no consumer here.
  assign w_unused_fwd_inputs = ^{memwb_reg_write, memwb_rd, memwb_result,
                                 exmem_result, r_rs1, r_rs2};
`endif

  // A flushed instruction is discarded anyway, so holding it gains nothing.
  assign stall = w_hazard & ~flush;

  // --------------------------------------------------------------------------
  // Pipeline register: reset > flush > stall > load. All three non-load
  // cases insert the same all-zero bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_op       <= '0;
      r_ctrl     <= '0;
    end else begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_op       <= id_alu_op;
      r_ctrl     <= w_id_ctrl;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign SrcA          = w_fwd_a;
  assign SrcB          = r_ctrl.alu_src ? r_imm : w_fwd_b;
  assign ex_store_data = w_fwd_b;
  assign Operation     = r_op;
  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_imm        = r_imm;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_branch     = r_ctrl.branch;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module    : tb_id_ex_stage
//  Purpose   : Directed self-checking bench for id_ex_stage. Sections that
//              depend on ID_EX_FWD_EN follow the same macro as the design.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_branch, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall;
  logic [31:0] SrcA, SrcB, ex_store_data, ex_pc, ex_imm;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_branch;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result), .stall(stall),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_alu_src = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    id_branch = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    // ---- reset with a valid ID instruction presented -----------------------
    reset = 1; idle();
    id_valid = 1; id_pc = 32'h44; id_rd = 5; id_reg_write = 1; id_mem_read = 1;
    id_alu_op = 4'b0010; id_rs1_data = 32'h99;
    tick(); tick();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_operation", Operation, 0);
    check("rst_reg_write", ex_reg_write, 0);
    check("rst_mem_read", ex_mem_read, 0);
    check("rst_ex_rd", ex_rd, 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_srca", SrcA, 0);
    check("rst_stall", stall, 0);
    reset = 0;

    // ---- plain register-register load into EX ------------------------------
    idle();
    id_valid = 1; id_pc = 32'h100; id_rs1 = 1; id_rs2 = 2; id_rd = 3;
    id_rs1_data = 32'hA; id_rs2_data = 32'hB; id_imm = 32'h40;
    id_alu_op = 4'b0010; id_reg_write = 1;
    settle();
    check("ld_stall", stall, 0);
    tick();
    check("ld_ex_valid", ex_valid, 1);
    check("ld_ex_pc", ex_pc, 32'h100);
    check("ld_operation", Operation, 4'b0010);
    check("ld_ex_rd", ex_rd, 3);
    check("ld_reg_write", ex_reg_write, 1);
    check("ld_srca", SrcA, 32'hA);
    check("ld_srcb", SrcB, 32'hB);
    check("ld_store_data", ex_store_data, 32'hB);
    check("ld_ex_imm", ex_imm, 32'h40);

    // ---- invalid ID: data captured, controls suppressed, no stall ----------
    idle();
    id_valid = 0; id_pc = 32'h104; id_rs1 = 3; id_rd = 6; id_imm = 32'h7;
    id_rs2_data = 32'hC; id_alu_src = 1; id_reg_write = 1; id_mem_write = 1;
    id_alu_op = 4'b0011;
    settle();
    check("inv_stall", stall, 0);
    tick();
    check("inv_ex_valid", ex_valid, 0);
    check("inv_reg_write", ex_reg_write, 0);
    check("inv_mem_write", ex_mem_write, 0);
    check("inv_ex_pc", ex_pc, 32'h104);
    check("inv_operation", Operation, 4'b0011);
    check("inv_store_data", ex_store_data, 32'hC);

    // ---- immediate operand -------------------------------------------------
    idle();
    id_valid = 1; id_pc = 32'h108; id_rs1 = 1; id_rs2 = 9; id_rd = 4;
    id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_imm = 32'h30;
    id_alu_src = 1; id_reg_write = 1; id_alu_op = 4'b0000; id_branch = 1;
    tick();
    check("imm_srca", SrcA, 32'h11);
    check("imm_srcb", SrcB, 32'h30);
    check("imm_store_data", ex_store_data, 32'h22);
    check("imm_branch", ex_branch, 1);

`ifdef ID_EX_FWD_EN
    // ---- forwarding priority: EX/MEM beats MEM/WB ---------------------------
    idle();
    id_valid = 1; id_rs1 = 3; id_rs2 = 3; id_rd = 8; id_rs1_data = 32'h1;
    id_rs2_data = 32'h2; id_alu_op = 4'b0010; id_reg_write = 1;
    tick();
    idle();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h10;
    settle();
    check("fwd_exmem_a", SrcA, 32'h10);
    check("fwd_exmem_store", ex_store_data, 32'h10);
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h20;
    settle();
    check("fwd_tie_a", SrcA, 32'h10);
    exmem_reg_write = 0;
    settle();
    check("fwd_memwb_a", SrcA, 32'h20);
    check("fwd_memwb_b", SrcB, 32'h20);
    memwb_rd = 4;
    settle();
    check("fwd_none_a", SrcA, 32'h1);

    // ---- x0 never forwarded ------------------------------------------------
    idle();
    id_valid = 1; id_rs1 = 0; id_rs2 = 0; id_rd = 9; id_reg_write = 1;
    tick();
    idle();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h55;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'h66;
    settle();
    check("x0_srca", SrcA, 0);
    check("x0_srcb", SrcB, 0);

    // ---- load-use stall ----------------------------------------------------
    idle();
    id_valid = 1; id_rs1 = 1; id_rd = 5; id_mem_read = 1; id_reg_write = 1;
    id_mem_to_reg = 1;
    tick();
    check("lu_ex_mem_read", ex_mem_read, 1);
    idle();
    id_valid = 1; id_pc = 32'h300; id_rs1 = 6; id_rs2 = 5; id_rd = 10;
    id_alu_src = 1; id_reg_write = 1;
    settle();
    check("lu_imm_no_stall", stall, 0);
    id_alu_src = 0;
    settle();
    check("lu_stall", stall, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rd", ex_rd, 0);
    check("lu_one_cycle", stall, 0);
    tick();
    check("lu_resume_pc", ex_pc, 32'h300);

    // ---- flush overrides a load-use stall ----------------------------------
    idle();
    id_valid = 1; id_rd = 5; id_mem_read = 1; id_reg_write = 1;
    tick();
    idle();
    id_valid = 1; id_rs1 = 5; id_rd = 12; id_reg_write = 1;
    settle();
    check("fl_stall_pre", stall, 1);
    flush = 1;
    settle();
    check("fl_stall", stall, 0);
    tick();
    check("fl_bubble_valid", ex_valid, 0);
    check("fl_bubble_rw", ex_reg_write, 0);
`else
    // ---- RAW stalls until producer leaves EX/MEM ----------------------------
    idle();
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 7; id_alu_op = 4'b0010;
    id_reg_write = 1;
    tick();
    idle();
    id_valid = 1; id_pc = 32'h200; id_rs1 = 7; id_rd = 11; id_reg_write = 1;
    settle();
    check("raw_stall_ex", stall, 1);
    tick();
    check("raw_bubble1", ex_valid, 0);
    exmem_reg_write = 1; exmem_rd = 7;
    settle();
    check("raw_stall_exmem", stall, 1);
    tick();
    check("raw_bubble2", ex_valid, 0);
    exmem_reg_write = 0; exmem_rd = 0;
    memwb_reg_write = 1; memwb_rd = 7;
    settle();
    check("raw_release", stall, 0);
    tick();
    check("raw_resume_valid", ex_valid, 1);
    check("raw_resume_pc", ex_pc, 32'h200);

    // ---- rs2 hazard only when rs2 is used; flush overrides -----------------
    idle();
    id_valid = 1; id_rs1 = 1; id_rs2 = 11; id_alu_src = 1;
    settle();
    check("rs2_unused", stall, 0);
    id_mem_write = 1;
    settle();
    check("rs2_store", stall, 1);
    flush = 1;
    settle();
    check("rs2_flush", stall, 0);
    tick();
    check("rs2_flush_bubble", ex_valid, 0);

    // ---- load-use also stalls without forwarding ---------------------------
    idle();
    id_valid = 1; id_rd = 5; id_mem_read = 1; id_reg_write = 1;
    tick();
    idle();
    id_valid = 1; id_rs2 = 5;
    settle();
    check("lu_stall", stall, 1);
    tick();
    check("lu_bubble", ex_valid, 0);

    // ---- x0 never a hazard, and no data forwarding -------------------------
    idle();
    id_valid = 1; id_rs1 = 2; id_rs1_data = 32'h33; id_rd = 0;
    id_reg_write = 1;
    tick();
    idle();
    id_valid = 1; id_rs1 = 0;
    exmem_reg_write = 1; exmem_rd = 0;
    settle();
    check("x0_no_stall", stall, 0);
    exmem_rd = 2; exmem_result = 32'h99;
    id_valid = 0;
    settle();
    check("nofwd_srca", SrcA, 32'h33);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
